// File: rtl/uart_pkg.sv
// Shared UART definitions: line states, bit-timing helper, default rates.
// Reused by the transmitter now and a receiver later.
package uart_pkg;

  localparam int unsigned DEF_CLK_HZ = 50_000_000;
  localparam int unsigned DEF_BAUD   = 115_200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic int unsigned clks_per_bit(
    input int unsigned clk_hz,
    input int unsigned baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the command parser and the UART transmitter.
// The parser is the master; the transmitter is the slave.
interface uart_tx_if;

  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       tx_accept;
  logic       tx_busy;

  modport master (
    output tx_start,
    output tx_byte,
    input  tx_ready,
    input  tx_accept,
    input  tx_busy
  );

  modport slave (
    input  tx_start,
    input  tx_byte,
    output tx_ready,
    output tx_accept,
    output tx_busy
  );

endinterface

// File: rtl/uart_baud_counter.sv
// Free-running bit-period counter; tick marks the last cycle of a bit.
// Clear holds it at zero so a frame always starts on a fresh period.
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 (or 8N2) UART transmitter with a ready/accept byte handshake.
// All outputs are registered; the start bit begins on the accepting edge.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = DEF_CLK_HZ,
  parameter int unsigned BAUD      = DEF_BAUD,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus,
  output logic       tx
);

  localparam int unsigned CLKS_PER_BIT =
    clks_per_bit(CLK_HZ, BAUD);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx: CLK_HZ/BAUD must be at least 2");
  end

  uart_state_t state, state_d;
  logic [7:0]  shift, shift_d;
  logic [2:0]  bit_cnt, bit_cnt_d;
  logic        stop_cnt, stop_cnt_d;
  logic        tx_d;
  logic        ready, ready_d;
  logic        busy;
  logic        accept, accept_d;
  logic        tick;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (state == IDLE),
    .en    (state != IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      ready    <= 1'b1;
      busy     <= 1'b0;
      accept   <= 1'b0;
    end else begin
      state    <= state_d;
      shift    <= shift_d;
      bit_cnt  <= bit_cnt_d;
      stop_cnt <= stop_cnt_d;
      tx       <= tx_d;
      ready    <= ready_d;
      busy     <= ~ready_d;
      accept   <= accept_d;
    end
  end

  always_comb begin
    state_d    = state;
    shift_d    = shift;
    bit_cnt_d  = bit_cnt;
    stop_cnt_d = stop_cnt;
    tx_d       = tx;
    ready_d    = ready;
    accept_d   = 1'b0;
    unique case (state)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (bus.tx_start) begin
          state_d    = START;
          shift_d    = bus.tx_byte;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b0;
          ready_d    = 1'b0;
          accept_d   = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shift[0];
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = {1'b0, shift[7:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          // bit_cnt wrapping past 7 closes the data field
          if (bit_cnt == 3'd7) begin
            state_d    = STOP;
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
          end else begin
            tx_d = shift[1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_cnt == LAST_STOP) begin
            state_d = IDLE;
            ready_d = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  assign bus.tx_ready  = ready;
  assign bus.tx_busy   = busy;
  assign bus.tx_accept = accept;

endmodule

// File: tb/tb_uart_tx.sv
// Randomised frame checks for uart_tx against a bit-position line model.
// Instance a: 4 clocks/bit, 1 stop; instance b: 2 clocks/bit, 2 stops.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txa, txb;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_if ifa ();
  uart_tx_if ifb ();

  uart_tx #(
    .CLK_HZ(400), .BAUD(100), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave), .tx(txa)
  );

  uart_tx #(
    .CLK_HZ(200), .BAUD(100), .STOP_BITS(2)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave), .tx(txb)
  );

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d",
                  tag, got, exp);
  endtask

  // Line level at a given cycle offset from the accepting edge
  function automatic int ref_bit(input logic [7:0] b,
                                 input int off, input int cpb);
    int idx;
    idx = off / cpb;
    if (idx == 0) return 0;
    if (idx <= 8) return int'(b[idx-1]);
    return 1;
  endfunction

  task automatic drive(input bit sel, input logic s,
                       input logic [7:0] b);
    if (sel) begin
      ifb.tx_start = s;
      ifb.tx_byte  = b;
    end else begin
      ifa.tx_start = s;
      ifa.tx_byte  = b;
    end
  endtask

  function automatic logic [3:0] obs(input bit sel);
    if (sel)
      return {txb, ifb.tx_ready, ifb.tx_busy, ifb.tx_accept};
    return {txa, ifa.tx_ready, ifa.tx_busy, ifa.tx_accept};
  endfunction

  task automatic chk_idle(input bit sel, input string tag);
    logic [3:0] o;
    o = obs(sel);
    chk({tag, "_tx"}, int'(o[3]), 1);
    chk({tag, "_ready"}, int'(o[2]), 1);
    chk({tag, "_busy"}, int'(o[1]), 0);
    chk({tag, "_accept"}, int'(o[0]), 0);
  endtask

  // Called at a negedge with the DUT idle. abort_at >= 0 asserts
  // reset at that offset instead of finishing the frame.
  task automatic frame(input bit sel, input logic [7:0] b,
                       input bit ff_noise, input int abort_at,
                       output int t_acc);
    int cpb;
    int len;
    logic [3:0] o;
    logic [7:0] dec;
    cpb = sel ? 2 : 4;
    len = sel ? 22 : 40;
    dec = '0;
    t_acc = -1;
    o = obs(sel);
    chk("pre_ready", int'(o[2]), 1);
    drive(sel, 1'b1, b);
    for (int off = 0; off < len; off++) begin
      @(posedge clk);
      @(negedge clk);
      o = obs(sel);
      if (off == 0) begin
        t_acc = cyc;
        chk("accept_pulse", int'(o[0]), 1);
        chk("ready_low", int'(o[2]), 0);
        chk("busy_high", int'(o[1]), 1);
      end else begin
        chk("accept_quiet", int'(o[0]), 0);
        chk("ready_busy", int'(o[2]), 0);
      end
      chk("tx_bit", int'(o[3]), ref_bit(b, off, cpb));
      if (off >= cpb && off < 9 * cpb && off % cpb == cpb / 2)
        dec[off / cpb - 1] = o[3];
      if (off == abort_at) begin
        drive(sel, 1'b0, 8'h00);
        rst = 1'b1;
        #1;
        chk_idle(sel, "rst_async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle(sel, "rst_release");
        return;
      end
      if (ff_noise) drive(sel, 1'b1, 8'hFF);
      else drive(sel, 1'($urandom_range(0, 1)), 8'($urandom));
    end
    chk("decoded", int'(dec), int'(b));
    @(posedge clk);
    @(negedge clk);
    chk_idle(sel, "frame_end");
    drive(sel, 1'b0, 8'($urandom));
  endtask

  initial begin
    int t0, t1, tdum;
    logic [7:0] msg [3];
    msg[0] = 8'h4F;
    msg[1] = 8'h4B;
    msg[2] = 8'h0A;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    chk_idle(1'b0, "reset_a");
    chk_idle(1'b1, "reset_b");
    rst = 1'b0;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk_idle(1'b0, "idle50");
    end

    frame(1'b0, 8'h4F, 1'b0, -1, tdum);

    // "OK\n" with start re-asserted on the first idle cycle
    t0 = -1;
    for (int i = 0; i < 3; i++) begin
      frame(1'b0, msg[i], 1'b0, -1, t1);
      if (i > 0) chk("stream_period", t1 - t0, 41);
      t0 = t1;
    end

    frame(1'b0, 8'h00, 1'b1, -1, tdum);
    repeat (3) begin
      @(negedge clk);
      chk_idle(1'b0, "after_ff");
    end

    repeat (4) frame(1'b0, 8'($urandom), 1'b0, -1, tdum);

    frame(1'b0, 8'h00, 1'b0, 17, tdum);
    frame(1'b0, 8'hA5, 1'b0, -1, tdum);

    frame(1'b1, 8'h80, 1'b0, -1, tdum);
    repeat (3) frame(1'b1, 8'($urandom), 1'b0, -1, tdum);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that drains the response byte stream produced by the command parser onto the board TX line. Each accepted byte becomes one 8N1 frame (optionally two stop bits) at a fixed baud rate. A ready/accept handshake lets the parser present one byte at a time and advance its response index exactly once per byte. The block sits between the command parser's `tx_start`/`tx_byte` outputs and the FPGA TX pin.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115_200: line rate in bit/s.
- `STOP_BITS`, default 1: 1 or 2; any other value is an elaboration error.
- `CLKS_PER_BIT`, derived as CLK_HZ/BAUD with integer truncation; must be ≥ 2, elaboration error otherwise.

Ports:
- `clk` input 1: single system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `tx_start` input 1: byte request; sampled only while `tx_ready`=1.
- `tx_byte` input 8: byte to send; sampled in the same cycle as an accepted `tx_start`.
- `tx_ready` output 1: idle, can accept a byte this cycle.
- `tx_accept` output 1: one-cycle pulse confirming a byte was latched.
- `tx_busy` output 1: frame in progress (inverse of `tx_ready`).
- `tx` output 1: serial line, idle high.

## Operation
- Reset values, all registered: `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_accept`=0, state IDLE, counters 0, shift register 0.
- States:
  - IDLE: on `tx_start`=1, latch `tx_byte` into the shift register, clear the bit counter, go to START.
  - START: drive `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: drive shift[0] for CLKS_PER_BIT cycles, then shift right. After 8 bits, LSB first, go to STOP.
  - STOP: drive `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. The bit boundary is the wrap cycle. The counter is cleared on entry to START.
- `tx_start` while not IDLE is ignored: no latch, no `tx_accept`, no error.
- `tx_byte` changes while busy have no effect on the frame in flight.
- Widths:
  - baud counter is $clog2(CLKS_PER_BIT) bits;
  - bit counter is 3 bits, wrapping 7→0 signals end of DATA;
  - stop counter is 1 bit.
- Reset asserted mid-frame: `tx` returns to 1 immediately (asynchronously). The partial frame is abandoned, with no resume after reset.

## Timing
- `tx_start` sampled at edge N in IDLE gives, from edge N:
  - `tx_accept`=1 for exactly one cycle (N to N+1);
  - `tx_ready`=0 and `tx_busy`=1;
  - `tx`=0 (start bit).
- Start bit covers cycles N..N+CPB-1. Data bit k covers N+(1+k)·CPB .. N+(2+k)·CPB-1.
- Stop bit(s) end at N+(9+STOP_BITS)·CPB. At that edge: state IDLE, `tx_ready`=1, `tx` stays 1.
- Parser compatibility:
  - the parser registers `tx_accept` and updates its byte 2 cycles later;
  - `tx_ready` is low for ≥ 10·CPB ≥ 20 cycles, so no stale byte is ever accepted.
- Back-to-back: if `tx_start` is held high at the first IDLE edge, the next start bit begins at that edge. The frame-to-frame period is (9+STOP_BITS)·CPB + 1 cycles (one idle cycle of `tx`=1 between frames).
- Accept latency from `tx_start` in IDLE: 0 cycles, since the start bit begins on the accepting edge.

## Structure
- Shared package `uart_pkg`:
  - state encoding (IDLE/START/DATA/STOP, 2 bits);
  - CLKS_PER_BIT derivation function;
  - default CLK_HZ/BAUD constants, reused by a future `uart_rx`.
- One sub-module, `uart_baud_counter`:
  - parameterised by CLKS_PER_BIT;
  - inputs `clk`, `rst`, `clear`, `en`;
  - output `tick` on the wrap cycle.
- The FSM, shift register and bit/stop counters stay in `uart_tx`.

## Test plan
- Reset then idle 50 cycles, CPB=4 → `tx`=1, `tx_ready`=1, `tx_accept`=0 throughout.
- Single byte 0x4F ("O"), CPB=4 → one `tx_accept` pulse; `tx` sequence 0,1,1,1,1,0,0,1,0,1, each bit exactly 4 cycles; `tx_ready` returns after 40 cycles.
- Parser-style stream "OK\n" (0x4F,0x4B,0x0A) with `tx_start` held high whenever ready → exactly 3 accepts, frames 41 cycles apart, decoded bytes match in order.
- `tx_start` pulsed with 0xFF mid-frame while sending 0x00 → no extra accept; line shows only 0x00, then idle.
- Reset asserted during data bit 3 → `tx`=1 in the same cycle, `tx_ready`=1 after release; next byte 0xA5 transmits cleanly.
- STOP_BITS=2, CPB=2, byte 0x80 → stop level high for 4 cycles; frame length 22 cycles.
